// File: rtl/wb_nor_arbiter.sv
// Two-master pipelined Wishbone arbiter sharing the NOR flash controller slave (m0 = QSPI bridge, m1 = control/debug).
// Define WB_ARB_TIMEOUT_EN to add a watchdog that aborts a grant whose slave stops responding.
module wb_nor_arbiter #(
    parameter int MAX_OUTST      = 15,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] m0_adr_i,
    input  logic [15:0] m0_dat_i,
    input  logic        m0_we_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic [15:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_stall_o,
    input  logic [31:0] m1_adr_i,
    input  logic [15:0] m1_dat_i,
    input  logic        m1_we_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic [15:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_stall_o,
    output logic [31:0] s_adr_o,
    output logic [15:0] s_dat_o,
    output logic        s_we_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic [15:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_stall_i,
    output logic [1:0]  grant_o
);

    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] OUTST_FULL = CW'(MAX_OUTST);

    typedef enum logic [1:0] {IDLE, G0, G1} state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] outst_q, outst_d;
    logic          sel1, granted, curCyc, curStb, othCyc;
    logic          full, busy, respIn, respValid, accept, timeout;

    assign sel1      = (state_q == G1);
    assign granted   = (state_q != IDLE);
    assign curCyc    = sel1 ? m1_cyc_i : m0_cyc_i;
    assign curStb    = sel1 ? m1_stb_i : m0_stb_i;
    assign othCyc    = sel1 ? m0_cyc_i : m1_cyc_i;
    assign full      = (outst_q == OUTST_FULL);
    assign busy      = (outst_q != '0);
    assign respIn    = s_ack_i | s_err_i;
    // A response with nothing outstanding is a stray: it is neither counted nor routed.
    assign respValid = respIn & busy;
    assign accept    = s_stb_o & ~s_stall_i;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);

    logic [WW-1:0] wdog_q, wdog_d;

    assign timeout = busy & ~respIn & (wdog_q == WDOG_LAST);

    always_comb begin
        wdog_d = '0;
        if (busy && !respIn && !timeout) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    // Watchdog compiled out; the limit is referenced but has no effect.
    assign timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

    // While the owner has dropped cyc with requests still in flight, the cycle is held open and acks are discarded.
    always_comb begin
        s_adr_o    = '0;
        s_dat_o    = '0;
        s_we_o     = 1'b0;
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        grant_o    = 2'b00;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m0_stall_o = 1'b1;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        m1_stall_o = 1'b1;
        if (granted) begin
            s_adr_o = sel1 ? m1_adr_i : m0_adr_i;
            s_dat_o = sel1 ? m1_dat_i : m0_dat_i;
            s_we_o  = sel1 ? m1_we_i  : m0_we_i;
            s_cyc_o = (curCyc | busy) & ~timeout;
            s_stb_o = curStb & curCyc & ~full & ~timeout;
            if (sel1) begin
                grant_o    = 2'b10;
                m1_ack_o   = s_ack_i & curCyc & busy;
                m1_err_o   = (s_err_i & curCyc & busy) | timeout;
                m1_stall_o = s_stall_i | full;
            end else begin
                grant_o    = 2'b01;
                m0_ack_o   = s_ack_i & curCyc & busy;
                m0_err_o   = (s_err_i & curCyc & busy) | timeout;
                m0_stall_o = s_stall_i | full;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        outst_d = outst_q;
        if (timeout) begin
            outst_d = '0;
        end else if (accept && !respValid) begin
            outst_d = outst_q + 1'b1;
        end else if (respValid && !accept) begin
            outst_d = outst_q - 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? G0 : G1;
                end else if (m0_cyc_i) begin
                    state_d = G0;
                end else if (m1_cyc_i) begin
                    state_d = G1;
                end
            end
            G0, G1: begin
                if (!curCyc && !busy) begin
                    last_d  = sel1;
                    state_d = othCyc ? (sel1 ? G0 : G1) : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            outst_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            outst_q <= outst_d;
        end
    end

endmodule

// File: tb/tb_wb_nor_arbiter.sv
// Self-checking bench for wb_nor_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// The watchdog scenario adapts its expectations to whether WB_ARB_TIMEOUT_EN is defined.
module tb_wb_nor_arbiter;

    localparam int TO = 32;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  mCyc, mStb, mWe;
    logic [31:0] mAdr [2];
    logic [15:0] mDat [2];
    logic [15:0] sDatIn;
    logic        sAck, sErr, sStall;
    wire  [15:0] m0DatO, m1DatO, sDatO;
    wire  [1:0]  mAck, mErr, mStall, grant;
    wire  [31:0] sAdr;
    wire         sWe, sStb, sCyc;

    int vecs = 0;
    int errs = 0;

    always #5 clk_i = ~clk_i;

    wb_nor_arbiter #(.MAX_OUTST(15), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_adr_i(mAdr[0]), .m0_dat_i(mDat[0]), .m0_we_i(mWe[0]), .m0_stb_i(mStb[0]), .m0_cyc_i(mCyc[0]),
        .m0_dat_o(m0DatO), .m0_ack_o(mAck[0]), .m0_err_o(mErr[0]), .m0_stall_o(mStall[0]),
        .m1_adr_i(mAdr[1]), .m1_dat_i(mDat[1]), .m1_we_i(mWe[1]), .m1_stb_i(mStb[1]), .m1_cyc_i(mCyc[1]),
        .m1_dat_o(m1DatO), .m1_ack_o(mAck[1]), .m1_err_o(mErr[1]), .m1_stall_o(mStall[1]),
        .s_adr_o(sAdr), .s_dat_o(sDatO), .s_we_o(sWe), .s_stb_o(sStb), .s_cyc_o(sCyc),
        .s_dat_i(sDatIn), .s_ack_i(sAck), .s_err_i(sErr), .s_stall_i(sStall),
        .grant_o(grant)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clearInputs();
        mCyc = '0; mStb = '0; mWe = '0;
        mAdr[0] = '0; mAdr[1] = '0; mDat[0] = '0; mDat[1] = '0;
        sDatIn = '0; sAck = 1'b0; sErr = 1'b0; sStall = 1'b0;
    endtask

    task automatic doReset();
        clearInputs();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        clearInputs();
        mCyc = 2'b11; mStb = 2'b11; mWe = 2'b11; mAdr[0] = 32'hDEAD_0000; mDat[0] = 16'h1234;
        sAck = 1'b1; sErr = 1'b1;
        rst_ni = 1'b0;
        tick();
        tick();
        settle();
        vecs++;
        if (grant !== 2'b00) begin errs++; $display("[TB] FAIL reset_grant: got %b want 00", grant); end
        vecs++;
        if ({sCyc, sStb, sWe} !== 3'b000) begin errs++; $display("[TB] FAIL reset_sctrl: got %b want 000", {sCyc, sStb, sWe}); end
        vecs++;
        if ({sAdr, sDatO} !== 48'h0) begin errs++; $display("[TB] FAIL reset_sbus: got %h want 0", {sAdr, sDatO}); end
        vecs++;
        if ({mAck, mErr, mStall} !== 6'b000011) begin errs++; $display("[TB] FAIL reset_resp: got %b want 000011", {mAck, mErr, mStall}); end
        rst_ni = 1'b1;
        clearInputs();
        tick();
    endtask

    task automatic test_single_read();
        doReset();
        mCyc[0] = 1'b1; mStb[0] = 1'b1; mAdr[0] = 32'h0000_0100;
        settle();
        vecs++;
        if ({grant, mStall[0]} !== 3'b001) begin errs++; $display("[TB] FAIL read_latency: got %b want 001", {grant, mStall[0]}); end
        tick();
        settle();
        vecs++;
        if (grant !== 2'b01) begin errs++; $display("[TB] FAIL read_grant: got %b want 01", grant); end
        vecs++;
        if ({sCyc, sStb, mStall} !== 4'b1110 || sAdr !== 32'h100) begin
            errs++; $display("[TB] FAIL read_fwd: got %b adr %h want 1110 adr 100", {sCyc, sStb, mStall}, sAdr);
        end
        tick();
        mStb[0] = 1'b0;
        tick();
        sAck = 1'b1; sDatIn = 16'hBEEF;
        settle();
        vecs++;
        if (mAck !== 2'b01 || m0DatO !== 16'hBEEF) begin errs++; $display("[TB] FAIL read_ack: got %b/%h want 01/beef", mAck, m0DatO); end
        tick();
        sAck = 1'b0; mCyc[0] = 1'b0;
        tick();
        settle();
        vecs++;
        if ({grant, sCyc} !== 3'b000) begin errs++; $display("[TB] FAIL read_release: got %b want 000", {grant, sCyc}); end
    endtask

    task automatic test_simultaneous();
        doReset();
        mCyc = 2'b11;
        tick();
        settle();
        vecs++;
        if ({grant, mStall} !== 4'b0110) begin errs++; $display("[TB] FAIL rr_first: got %b want 0110", {grant, mStall}); end
        mCyc[0] = 1'b0;
        tick();
        settle();
        vecs++;
        if ({grant, sCyc} !== 3'b101) begin errs++; $display("[TB] FAIL rr_handover: got %b want 101", {grant, sCyc}); end
        mCyc[1] = 1'b0;
        tick();
        mCyc[0] = 1'b1;
        tick();
        settle();
        vecs++;
        if (grant !== 2'b01) begin errs++; $display("[TB] FAIL rr_single: got %b want 01", grant); end
        mCyc[0] = 1'b0;
        tick();
        mCyc = 2'b11;
        tick();
        settle();
        vecs++;
        if (grant !== 2'b10) begin errs++; $display("[TB] FAIL rr_second: got %b want 10", grant); end
        mCyc = 2'b00;
        tick();
    endtask

    task automatic test_pipeline_fill();
        int cnt;
        doReset();
        mCyc[1] = 1'b1; mStb[1] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 22; i++) begin
            settle();
            if (sStb === 1'b1) cnt++;
            tick();
        end
        settle();
        vecs++;
        if (cnt != 15) begin errs++; $display("[TB] FAIL fill_count: got %0d want 15", cnt); end
        vecs++;
        if ({mStall[1], sStb} !== 2'b10) begin errs++; $display("[TB] FAIL fill_stall: got %b want 10", {mStall[1], sStb}); end
        sAck = 1'b1;
        settle();
        vecs++;
        if (mAck !== 2'b10) begin errs++; $display("[TB] FAIL fill_ack: got %b want 10", mAck); end
        tick();
        sAck = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            settle();
            if (sStb === 1'b1) cnt++;
            tick();
        end
        vecs++;
        if (cnt != 1) begin errs++; $display("[TB] FAIL fill_refill: got %0d want 1", cnt); end
    endtask

    task automatic test_early_drop();
        doReset();
        mCyc = 2'b11; mStb[0] = 1'b1;
        repeat (4) tick();
        mCyc[0] = 1'b0; mStb[0] = 1'b0;
        settle();
        vecs++;
        if ({sCyc, grant, mStall[1]} !== 4'b1011) begin errs++; $display("[TB] FAIL drop_hold: got %b want 1011", {sCyc, grant, mStall[1]}); end
        for (int k = 0; k < 3; k++) begin
            tick();
            sAck = 1'b0;
            settle();
            vecs++;
            if (sCyc !== 1'b1) begin errs++; $display("[TB] FAIL drop_cyc_%0d: got %b want 1", k, sCyc); end
            tick();
            sAck = 1'b1;
            settle();
            vecs++;
            if ({mAck, sCyc} !== 3'b001) begin errs++; $display("[TB] FAIL drop_discard_%0d: got %b want 001", k, {mAck, sCyc}); end
        end
        tick();
        sAck = 1'b0;
        settle();
        vecs++;
        if ({grant, sCyc} !== 3'b010) begin errs++; $display("[TB] FAIL drop_drained: got %b want 010", {grant, sCyc}); end
        tick();
        settle();
        vecs++;
        if ({grant, sCyc} !== 3'b101) begin errs++; $display("[TB] FAIL drop_handover: got %b want 101", {grant, sCyc}); end
    endtask

    task automatic test_reset_mid();
        doReset();
        mCyc[0] = 1'b1; mStb[0] = 1'b1;
        repeat (5) tick();
        settle();
        vecs++;
        if ({grant, sCyc} !== 3'b011) begin errs++; $display("[TB] FAIL midrst_pre: got %b want 011", {grant, sCyc}); end
        rst_ni = 1'b0;
        tick();
        settle();
        vecs++;
        if ({sCyc, mStall, grant} !== 5'b01100) begin errs++; $display("[TB] FAIL midrst_state: got %b want 01100", {sCyc, mStall, grant}); end
        rst_ni = 1'b1;
        mCyc = 2'b00; mStb = 2'b00; sAck = 1'b1;
        settle();
        vecs++;
        if (mAck !== 2'b00) begin errs++; $display("[TB] FAIL midrst_stray: got %b want 00", mAck); end
        tick();
        sAck = 1'b0;
    endtask

    task automatic test_timeout();
        logic expErr;
        doReset();
        mCyc[0] = 1'b1; mStb[0] = 1'b1;
        tick();
        tick();
        mStb[0] = 1'b0;
        for (int i = 1; i <= TO + 8; i++) begin
            settle();
            expErr = TO_EN && (i == TO);
            vecs++;
            if (mErr !== {1'b0, expErr} || sCyc !== !expErr) begin
                errs++; $display("[TB] FAIL timeout_c%0d: err %b cyc %b want err %b cyc %b", i, mErr, sCyc, {1'b0, expErr}, !expErr);
            end
            tick();
        end
        mCyc[0] = 1'b0;
        tick();
    endtask

    // Transaction-level reference: owner, round-robin history and in-flight request count.
    task automatic test_random();
        int owner, lastM, outM, quiet, oldOut;
        logic c, full, busy, acc, resp;
        logic [1:0]  eG, eA, eE, eSt;
        logic        eC, eS, eWe;
        logic [31:0] eAdr;
        logic [15:0] eDat;
        doReset();
        owner = -1; lastM = 1; outM = 0; quiet = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int m = 0; m < 2; m++) begin
                if (mCyc[m]) begin
                    if ($urandom_range(7) == 0) mCyc[m] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    mCyc[m] = 1'b1;
                end
                mStb[m] = mCyc[m] & ($urandom_range(1) == 1);
                mWe[m]  = ($urandom_range(1) == 1);
                mAdr[m] = $urandom;
                mDat[m] = 16'($urandom);
            end
            sStall = ($urandom_range(3) == 0);
            sErr   = ($urandom_range(15) == 0);
            sAck   = ($urandom_range(1) == 1) || (quiet >= 4);
            sDatIn = 16'($urandom);
            settle();
            eG = '0; eA = '0; eE = '0; eSt = 2'b11; eC = 1'b0; eS = 1'b0; eWe = 1'b0; eAdr = '0; eDat = '0;
            busy = (outM > 0);
            full = (outM == 15);
            c = 1'b0;
            if (owner >= 0) begin
                c = mCyc[owner];
                eG[owner]  = 1'b1;
                eC         = c || busy;
                eS         = mStb[owner] && c && !full;
                eA[owner]  = sAck && c && busy;
                eE[owner]  = sErr && c && busy;
                eSt[owner] = sStall || full;
                eAdr = mAdr[owner]; eDat = mDat[owner]; eWe = mWe[owner];
            end
            vecs++;
            if ({grant, sCyc, sStb, mAck, mErr, mStall} !== {eG, eC, eS, eA, eE, eSt}) begin
                errs++; $display("[TB] FAIL rand_ctrl_%0d: got %b want %b", n, {grant, sCyc, sStb, mAck, mErr, mStall}, {eG, eC, eS, eA, eE, eSt});
            end
            vecs++;
            if ({sAdr, sDatO, sWe} !== {eAdr, eDat, eWe} || m0DatO !== sDatIn || m1DatO !== sDatIn) begin
                errs++; $display("[TB] FAIL rand_data_%0d: got %h/%h/%b want %h/%h/%b", n, sAdr, sDatO, sWe, eAdr, eDat, eWe);
            end
            acc  = eS && !sStall;
            resp = (sAck || sErr) && busy;
            quiet = (busy && !resp) ? quiet + 1 : 0;
            oldOut = outM;
            outM = outM + (acc ? 1 : 0) - (resp ? 1 : 0);
            if (owner < 0) begin
                if (mCyc == 2'b11) owner = (lastM == 1) ? 0 : 1;
                else if (mCyc[0]) owner = 0;
                else if (mCyc[1]) owner = 1;
            end else if (!c && oldOut == 0) begin
                lastM = owner;
                owner = mCyc[1 - owner] ? 1 - owner : -1;
            end
            tick();
        end
        clearInputs();
    endtask

    initial begin
        rst_ni = 1'b0;
        clearInputs();
        test_reset();
        test_single_read();
        test_simultaneous();
        test_pipeline_fill();
        test_early_drop();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation did not complete in time");
        $fatal(1, "[TB] time limit exceeded");
    end

endmodule

// File: doc/wb_nor_arbiter.md
# wb_nor_arbiter

Two-master Wishbone (pipelined, 32-bit address / 16-bit data) arbiter that shares the single NOR flash controller slave between the QSPI bridge (master 0) and the control/debug master (master 1). Sits between the bridge/control Wishbone masters and the NOR controller in `top`. It grants whole bus cycles (held for the duration of `cyc`) with round-robin fairness. It tracks outstanding pipelined requests, so acks are routed to the correct master and the slave is never over-subscribed.

## Interface
- `MAX_OUTST`, default 15: maximum un-acked requests per grant; outstanding counter width is `$clog2(MAX_OUTST+1)`.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit, used only when `WB_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk_i`  in  1  system clock
- `rst_ni`  in  1  reset, synchronous, active-low
- `m0_adr_i`, `m1_adr_i`  in  32  master address
- `m0_dat_i`, `m1_dat_i`  in  16  master write data
- `m0_we_i`, `m0_stb_i`, `m0_cyc_i`, `m1_we_i`, `m1_stb_i`, `m1_cyc_i`  in  1 each  master controls
- `m0_dat_o`, `m1_dat_o`  out  16  read data; both are driven from `s_dat_i`
- `m0_ack_o`, `m0_err_o`, `m0_stall_o`, `m1_ack_o`, `m1_err_o`, `m1_stall_o`  out  1 each  master responses
- `s_adr_o`  out  32  slave address
- `s_dat_o`  out  16  slave write data
- `s_we_o`, `s_stb_o`, `s_cyc_o`  out  1 each  slave controls
- `s_dat_i`  in  16  slave read data
- `s_ack_i`, `s_err_i`, `s_stall_i`  in  1 each  slave responses
- `grant_o`  out  2  one-hot current grant (bit0 = m0); 0 when idle

## Operation
- States:
  - `IDLE`: `grant_o` = 0.
  - `G0`: master 0 granted.
  - `G1`: master 1 granted.
- `IDLE`:
  - Only m0 has `cyc` high → go to `G0`.
  - Only m1 has `cyc` high → go to `G1`.
  - Both → grant the master that is not `last`. `last` resets to 1, so m0 wins first after reset.
- `Gx`:
  - Hold while `mx_cyc_i` = 1.
  - When `mx_cyc_i` = 0: go to the other grant if that master's `cyc` = 1; otherwise go to `IDLE`.
  - On every release, `last` ← x.
- Forwarding (combinational, from the granted master):
  - `s_adr_o`, `s_dat_o`, `s_we_o` pass through.
  - `s_cyc_o` = `mx_cyc_i`.
  - `s_stb_o` = `mx_stb_i & ~full`.
  - In `IDLE`: `s_cyc_o` = `s_stb_o` = 0; adr/dat/we = 0.
- Granted master responses:
  - `mx_ack_o` = `s_ack_i`.
  - `mx_err_o` = `s_err_i`.
  - `mx_stall_o` = `s_stall_i | full`.
- Non-granted master: `stall` = 1, `ack` = 0, `err` = 0.
- Outstanding counter `outst`:
  - +1 on `s_stb_o & ~s_stall_i`.
  - −1 on `s_ack_i | s_err_i`.
  - Simultaneous increment and decrement → unchanged.
  - `full` = (`outst` == `MAX_OUTST`).
  - Never wraps. A decrement at 0 is ignored, and the stray ack/err is dropped (not routed to any master).
- Grant release with `outst` ≠ 0 (master dropped `cyc` early):
  - `s_cyc_o` is held at 1 and no new grant is issued until `outst` = 0.
  - Remaining acks are discarded.

## Timing
- Reset values:
  - `s_cyc_o`, `s_stb_o`, `s_we_o` = 0; `s_adr_o`, `s_dat_o` = 0.
  - All acks and errs = 0; both stalls = 1.
  - `grant_o` = 0, `outst` = 0, `last` = 1.
- Grant latency: `cyc` rising in cycle N (from `IDLE`) → grant state from edge N+1. `s_cyc_o` = 1 and that master's stall can drop in cycle N+1.
- Handover: m0 drops `cyc` in cycle N with m1 waiting and `outst` = 0 → `G1` in cycle N+1. No idle bus cycle.
- Ack path is zero-latency (combinational) slave→master. The stb path is also zero-latency.
- Throughput: 1 request/cycle while `~s_stall_i & ~full`.
- Reset asserted mid-transfer: at the next edge, all state returns to reset values and `s_cyc_o` = 0. Acks that arrive afterward are dropped.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined:
  - A watchdog counter runs while `outst` ≠ 0 and no ack/err arrives. It clears on any ack/err or when `outst` = 0.
  - When it reaches `TIMEOUT_CYCLES−1`: pulse `mx_err_o` = 1 for one cycle to the granted master, force `s_cyc_o` = 0 that cycle, and clear `outst` to 0. Grant then follows normal release rules.
- `WB_ARB_TIMEOUT_EN` undefined: no counter. Errors come only from `s_err_i`, and a hung slave holds the grant indefinitely.

## Test plan
- Single m0 read: m0 `cyc`/`stb` at `adr` 0x100, slave acks 2 cycles later with `s_dat_i` 0xBEEF → `grant_o` = 01 one cycle after `cyc`; m0 `ack` = 1 with data 0xBEEF; `m1_ack_o` stays 0.
- Simultaneous request after reset: both `cyc` rise in the same cycle → m0 granted first. On m0 release, `grant_o` = 10 the next cycle with no idle cycle. A later simultaneous request → m1 granted.
- Pipeline fill: m1 issues 20 back-to-back stbs while the slave never stalls and withholds acks → exactly 15 stbs reach the slave, then `m1_stall_o` = 1. After one ack, exactly one more stb is accepted.
- Early cyc drop: m0 drops `cyc` with 3 outstanding and m1 requesting → `s_cyc_o` stays 1 until the 3rd ack; the acks reach neither master; `grant_o` = 10 the cycle after `outst` = 0.
- Reset mid-burst: `rst_ni` = 0 with `outst` = 4 → next cycle `s_cyc_o` = 0, both stalls = 1, `grant_o` = 0.
- With `WB_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8: one stb and the slave never acks → `m0_err_o` pulses 1 cycle with `s_cyc_o` = 0 in that same cycle. Without the macro, no err ever.
